// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes,
// default bit period and the frame parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DEFAULT_CLOCKS_PER_BIT = 87;

    // Bit that makes the frame's data+parity ones count even (or odd).
    function automatic logic parity_bit(
        input logic [7:0] data,
        input int         mode
    );
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit period timer, shared by the UART transmitter and receiver.
// Ports: clock_i, reset_n_i, restart (zero the count), tick (last cycle of a bit).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic restart,
    output logic tick
);

    localparam int W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLOCKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 8 data LSB first, optional parity, 1/2 stop bits.
// Ports: clock_i, reset_n_i, data_i/valid_i/ready_o (byte in), serial_o, busy_o.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int PARITY         = PARITY_NONE,
    parameter int STOP_BITS      = 1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       serial_o,
    output logic       busy_o
);

    localparam logic HAS_PAR   = (PARITY != PARITY_NONE);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_nxt;
    logic       r_stop_idx;
    logic       w_stop_idx_nxt;
    logic       r_parity;
    logic       w_parity_nxt;
    logic [7:0] r_hold;
    logic       r_hold_valid;
    logic       r_serial;
    logic       w_serial_nxt;
    logic       w_load;
    logic       w_restart;
    logic       w_accept;
    logic       w_tick;

    uart_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_timer (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .restart  (w_restart),
        .tick     (w_tick)
    );

    assign w_accept = valid_i & ~r_hold_valid;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_serial   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_parity   <= w_parity_nxt;
            r_serial   <= w_serial_nxt;
        end
    end

    // Holding register: empties on hand-off, refills on accept.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= data_i;
            end
            r_hold_valid <= w_accept | (r_hold_valid & ~w_load);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_load         = 1'b0;
        w_restart      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_restart   = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt    = HAS_PAR ? ST_PARITY : ST_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = ST_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == LAST_STOP) begin
                        // Timer wraps to 0 on its own here, so a queued
                        // byte starts with no idle gap.
                        if (r_hold_valid) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_START;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_nxt = r_hold;
        end
        w_parity_nxt = w_load ? parity_bit(r_hold, PARITY) : r_parity;

        // Line level is registered from the next state.
        unique case (w_state_nxt)
            ST_START:  w_serial_nxt = 1'b0;
            ST_DATA:   w_serial_nxt = w_shift_nxt[0];
            ST_PARITY: w_serial_nxt = w_parity_nxt;
            default:   w_serial_nxt = 1'b1;
        endcase
    end

    assign ready_o  = ~r_hold_valid;
    assign serial_o = r_serial;
    assign busy_o   = (r_state != ST_IDLE) | r_hold_valid;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level line model per instance,
// directed timing cases on the default instance, random traffic on others.
module tb_uart_tx;

    localparam int N = 4;
    localparam int CPB_A [N] = '{87, 7, 5, 2};
    localparam int PAR_A [N] = '{0, 1, 2, 0};
    localparam int STP_A [N] = '{1, 1, 2, 2};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] vld = '0;
    logic [N-1:0] ser;
    logic [N-1:0] rdy;
    logic [N-1:0] bsy;
    logic [7:0]   dat [N];

    int checks = 0;
    int failures = 0;

    logic [7:0]  q [N][$];
    bit          m_act [N];
    bit          m_hv [N];
    logic [7:0]  m_hb [N];
    logic [11:0] m_fr [N];
    int          m_t [N];
    int          m_len [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx #(
            .CLOCKS_PER_BIT(CPB_A[g]),
            .PARITY        (PAR_A[g]),
            .STOP_BITS     (STP_A[g])
        ) u_dut (
            .clock_i  (clk),
            .reset_n_i(rst_n),
            .data_i   (dat[g]),
            .valid_i  (vld[g]),
            .ready_o  (rdy[g]),
            .serial_o (ser[g]),
            .busy_o   (bsy[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Whole frame as a bit vector, index 0 = start bit; unused top bits are 1.
    function automatic logic [11:0] frame_of(input logic [7:0] d, input int p);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (p != 0) f[9] = (^d) ^ (p == 2);
        return f;
    endfunction

    function automatic int flen(input int p, input int s);
        return 10 + ((p != 0) ? 1 : 0) + (s - 1);
    endfunction

    function automatic logic exp_ser(input int i);
        if (!m_act[i]) return 1'b1;
        return m_fr[i][m_t[i] / CPB_A[i]];
    endfunction

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit acc;
            if (!rst_n) begin
                m_act[i] = 0;
                m_hv[i] = 0;
                m_t[i] = 0;
            end else begin
                acc = vld[i] && !m_hv[i];
                if (!m_act[i] || m_t[i] == m_len[i] * CPB_A[i] - 1) begin
                    if (m_hv[i]) begin
                        m_act[i] = 1;
                        m_t[i] = 0;
                        m_fr[i] = frame_of(m_hb[i], PAR_A[i]);
                        m_len[i] = flen(PAR_A[i], STP_A[i]);
                        m_hv[i] = 0;
                    end else begin
                        m_act[i] = 0;
                    end
                end else begin
                    m_t[i]++;
                end
                if (acc) begin
                    m_hv[i] = 1;
                    m_hb[i] = dat[i];
                    if (q[i].size() > 0) void'(q[i].pop_front());
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("ser%0d", i), ser[i], exp_ser(i));
                check($sformatf("rdy%0d", i), rdy[i], !m_hv[i]);
                check($sformatf("bsy%0d", i), bsy[i], m_act[i] || m_hv[i]);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) dat[i] = '0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0) begin
                    vld[i] = 1'b0;
                end else begin
                    vld[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    dat[i] = q[i][0];
                end
            end
        end
    end

    task automatic wait_fall0(output bit ok);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (ser[0] == 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL start_timeout actual=none expected=start bit");
        end
    endtask

    // Follows instance 0 from its start bit until busy drops.
    task automatic watch0(input logic [19:0] bits, input int nbits,
                          output int dur);
        bit ok;
        int c;
        wait_fall0(ok);
        dur = -1;
        if (ok) begin
            c = 0;
            while (bsy[0] && c < 5000) begin
                @(posedge clk);
                #1;
                c++;
                if (c % 87 == 43 && c / 87 < nbits)
                    check($sformatf("bit%0d", c / 87), ser[0], bits[c / 87]);
                if (nbits == 20 && c == 100) check("hold_full", rdy[0], 0);
                if (nbits == 20 && c == 900) check("hold_free", rdy[0], 1);
            end
            dur = c;
        end
    endtask

    initial begin
        logic [11:0] f;
        int dur;
        bit ok;
        bit done;

        f = frame_of(8'h33, 1);
        check("par33_even", f[9], 0);
        f = frame_of(8'h33, 2);
        check("par33_odd", f[9], 1);
        f = frame_of(8'h07, 1);
        check("par07_even", f[9], 1);
        f = frame_of(8'h55, 0);
        check("frame55", f[9:0], 10'b1010101010);
        check("len_par", flen(1, 1) * 87, 957);
        check("len_stop2", flen(0, 2) * 87, 957);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_ser%0d", i), ser[i], 1);
            check($sformatf("rst_rdy%0d", i), rdy[i], 1);
            check($sformatf("rst_bsy%0d", i), bsy[i], 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 1; i < N; i++)
            for (int k = 0; k < 40; k++)
                q[i].push_back(8'($urandom_range(0, 255)));

        q[0].push_back(8'h55);
        watch0({10'h3ff, 1'b1, 8'h55, 1'b0}, 10, dur);
        check("dur55", dur, 870);

        q[0].push_back(8'hAA);
        q[0].push_back(8'hCC);
        watch0({1'b1, 8'hCC, 1'b0, 1'b1, 8'hAA, 1'b0}, 20, dur);
        check("dur_aa_cc", dur, 1740);

        q[0].push_back(8'hF0);
        wait_fall0(ok);
        if (ok) begin
            repeat (380) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            for (int i = 0; i < N; i++) begin
                check($sformatf("async_ser%0d", i), ser[i], 1);
                check($sformatf("async_rdy%0d", i), rdy[i], 1);
                check($sformatf("async_bsy%0d", i), bsy[i], 0);
            end
            q[0].delete();
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
        end

        q[0].push_back(8'h0F);
        watch0({10'h3ff, 1'b1, 8'h0F, 1'b0}, 10, dur);
        check("dur0f", dur, 870);

        done = 0;
        for (int k = 0; k < 20000 && !done; k++) begin
            @(posedge clk);
            #1;
            done = 1;
            for (int i = 0; i < N; i++)
                if (q[i].size() != 0 || bsy[i]) done = 0;
        end
        check("drain", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
